// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds the fetched word for the decoder until the core asks for the next one.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [5:0]        INSTop,
  output logic [5:0]        funct,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              advance,
  input  logic [1:0]        AddrSrc,
  input  logic              br_taken,
  input  logic [31:0]       reg_target,
  output logic              misalign,
  output logic [31:0]       inst_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_plus4_r;
  logic [31:0]       inst_r;
  logic              inst_valid_r;
  logic              imem_req_r;
  logic              misalign_r;
  logic [31:0]       inst_count_r;

  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              mis_s;

  // Word offset of a branch: sign-extended imm16 scaled by four.
  assign br_off_s = {{(ADDR_W-18){inst_r[15]}}, inst_r[15:0], 2'b00};

  // Next-PC selection from the held instruction and the decoder's source select.
  always_comb begin
    next_pc_s = pc_plus4_r;
    mis_s     = 1'b0;
    case (AddrSrc)
      2'b00: next_pc_s = pc_plus4_r;
      2'b01: begin
        if (br_taken) begin
          next_pc_s = pc_plus4_r + br_off_s;
        end else begin
          next_pc_s = pc_plus4_r;
        end
      end
      2'b10: next_pc_s = {pc_plus4_r[ADDR_W-1:28], inst_r[25:0], 2'b00};
      2'b11: begin
        next_pc_s = {reg_target[ADDR_W-1:2], 2'b00};
        mis_s     = |reg_target[1:0];
      end
      default: next_pc_s = pc_plus4_r;
    endcase
  end

  // Fetch sequencer with all visible outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      pc_plus4_r   <= RESET_PC + ADDR_W'(32'd4);
      inst_r       <= 32'd0;
      inst_valid_r <= 1'b0;
      imem_req_r   <= 1'b0;
      misalign_r   <= 1'b0;
      inst_count_r <= 32'd0;
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        BOOT: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_r       <= imem_rdata;
            inst_valid_r <= 1'b1;
            imem_req_r   <= 1'b0;
            state_r      <= HOLD;
          end
        end
        HOLD: begin
          // Retire the held instruction and launch the fetch of its successor.
          if (advance) begin
            pc_r         <= next_pc_s;
            pc_plus4_r   <= next_pc_s + ADDR_W'(32'd4);
            inst_count_r <= inst_count_r + 32'd1;
            misalign_r   <= mis_s;
            inst_valid_r <= 1'b0;
            imem_req_r   <= 1'b1;
            state_r      <= FETCH;
          end
        end
        default: begin
          state_r      <= BOOT;
          inst_valid_r <= 1'b0;
          imem_req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign inst       = inst_r;
  assign INSTop     = inst_r[31:26];
  assign funct      = inst_r[5:0];
  assign inst_valid = inst_valid_r;
  assign pc         = pc_r;
  assign pc_plus4   = pc_plus4_r;
  assign misalign   = misalign_r;
  assign inst_count = inst_count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a memory responder, a stimulus process
// with a reference next-PC model, and a monitor that checks every fetch and hold.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  INSTop;
  logic [5:0]  funct;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic [1:0]  AddrSrc;
  logic        br_taken;
  logic [31:0] reg_target;
  logic        misalign;
  logic [31:0] inst_count;

  // Second instance booting at the top of the address space for the wrap case.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_adv;
  logic [1:0]  w_src;
  logic        w_bt;
  logic [31:0] w_rt;
  logic        w_mis;
  logic [31:0] w_cnt;

  pc_fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .INSTop(INSTop),
    .funct(funct), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .AddrSrc(AddrSrc), .br_taken(br_taken),
    .reg_target(reg_target), .misalign(misalign), .inst_count(inst_count)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst(w_inst), .INSTop(w_op),
    .funct(w_fn), .inst_valid(w_valid), .pc(w_pc), .pc_plus4(w_pc4),
    .advance(w_adv), .AddrSrc(w_src), .br_taken(w_bt),
    .reg_target(w_rt), .misalign(w_mis), .inst_count(w_cnt)
  );

  assign w_ack   = w_req;
  assign w_rdata = 32'h0000_0000;
  assign w_src   = 2'b00;
  assign w_bt    = 1'b0;
  assign w_rt    = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [bit [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          mem_hold  = 1'b0;
  bit          force_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] s, input logic b,
                                           input logic [31:0] r);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(w[15:0]));
    case (s)
      2'b01:   return b ? seq + 32'(off * 4) : seq;
      2'b10:   return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
      2'b11:   return r & ~32'd3;
      default: return seq;
    endcase
  endfunction

  // Memory responder: random 0..2 cycle latency, optional hold-off and stray ack.
  initial begin
    int dly;
    dly = -1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (!rst) begin
        dly = -1;
      end else if (force_ack) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        force_ack = 1'b0;
      end else if (imem_req && !mem_hold) begin
        if (dly < 0) dly = $urandom_range(0, 2);
        if (dly == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_read(imem_addr);
          dly = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  // Monitor: pops one expectation per fetch request and checks the held state.
  initial begin
    exp_t cur;
    bit   have_cur, prev_req, prev_ackreq;
    have_cur = 1'b0;
    prev_req = 1'b0;
    prev_ackreq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur = 1'b0;
        prev_req = 1'b0;
        prev_ackreq = 1'b0;
        continue;
      end
      if (prev_ackreq) check("ack_to_valid", 32'(inst_valid), 32'd1);
      if (imem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", imem_addr, 32'hXXXX_XXXX);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("fetch_addr", imem_addr, cur.addr);
          check("misalign_pulse", 32'(misalign), 32'(cur.mis));
          check("count_at_fetch", inst_count, cur.cnt);
        end
      end else begin
        check("misalign_idle", 32'(misalign), 32'd0);
        if (imem_req && have_cur) check("addr_stable", imem_addr, cur.addr);
      end
      if (inst_valid && have_cur) begin
        check("held_inst", inst, mem_read(cur.addr));
        check("held_pc", pc, cur.addr);
        check("held_pc_plus4", pc_plus4, cur.addr + 32'd4);
        check("INSTop", 32'(INSTop), 32'(mem_read(cur.addr) >> 26));
        check("funct", 32'(funct), mem_read(cur.addr) & 32'h3F);
        check("held_count", inst_count, cur.cnt);
      end
      prev_req = imem_req;
      prev_ackreq = imem_req && imem_ack;
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!inst_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_timeout", 32'(inst_valid), 32'd1);
  endtask

  task automatic issue_adv(input logic [1:0] s, input logic b, input logic [31:0] r,
                           input logic [31:0] exp_next);
    exp_t e;
    AddrSrc = s;
    br_taken = b;
    reg_target = r;
    advance = 1'b1;
    m_count = m_count + 32'd1;
    e.addr = exp_next;
    e.cnt = m_count;
    e.mis = (s == 2'b11) && (r % 32'd4 != 32'd0);
    exp_q.push_back(e);
    m_pc = exp_next;
    @(posedge clk); #1;
    advance = 1'b0;
    AddrSrc = 2'($urandom);
    br_taken = 1'($urandom);
    reg_target = $urandom;
  endtask

  task automatic boot_model();
    exp_t e;
    exp_q.delete();
    m_pc = 32'h0000_3000;
    m_count = 32'd0;
    e.addr = 32'h0000_3000;
    e.cnt = 32'd0;
    e.mis = 1'b0;
    exp_q.push_back(e);
  endtask

  // Stimulus: directed cases first, then randomized traffic, reset and wrap.
  initial begin
    logic [1:0]  s;
    logic        b;
    logic [31:0] r;
    int          n;
    advance = 1'b0;
    AddrSrc = 2'b00;
    br_taken = 1'b0;
    reg_target = 32'd0;
    w_adv = 1'b0;
    mem[32'h0000_3000] = 32'h0800_0C10;
    mem[32'h0000_3010] = 32'h1000_FFFE;
    boot_model();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_inst", inst, 32'd0);
    check("rst_count", inst_count, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b1;
    check("boot_idle", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    check("boot_req", 32'(imem_req), 32'd1);
    check("boot_addr", imem_addr, 32'h0000_3000);

    wait_valid();
    issue_adv(2'b00, 1'b0, 32'd0, 32'h0000_3004);
    wait_valid();
    issue_adv(2'b00, 1'b0, 32'd0, 32'h0000_3008);
    wait_valid();
    issue_adv(2'b00, 1'b0, 32'd0, 32'h0000_300C);
    wait_valid();
    check("count_three", inst_count, 32'd3);
    issue_adv(2'b00, 1'b0, 32'd0, 32'h0000_3010);
    wait_valid();
    issue_adv(2'b01, 1'b1, 32'd0, 32'h0000_300C);
    wait_valid();
    issue_adv(2'b00, 1'b0, 32'd0, 32'h0000_3010);
    wait_valid();
    issue_adv(2'b01, 1'b0, 32'd0, 32'h0000_3014);
    wait_valid();
    issue_adv(2'b11, 1'b0, 32'h0000_3043, 32'h0000_3040);
    check("misalign_high", 32'(misalign), 32'd1);
    @(posedge clk); #1;
    check("misalign_one_cycle", 32'(misalign), 32'd0);
    wait_valid();
    issue_adv(2'b11, 1'b0, 32'h0000_3000, 32'h0000_3000);
    wait_valid();
    issue_adv(2'b10, 1'b0, 32'd0, 32'h0000_3040);

    // Stray advance during FETCH, then stray ack during HOLD.
    wait_valid();
    mem_hold = 1'b1;
    issue_adv(2'b00, 1'b0, 32'd0, ref_next(m_pc, mem_read(m_pc), 2'b00, 1'b0, 32'd0));
    AddrSrc = 2'b10;
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_hold = 1'b0;
    wait_valid();
    force_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      wait_valid();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      s = 2'($urandom);
      b = 1'($urandom);
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
      issue_adv(s, b, r, ref_next(m_pc, mem_read(m_pc), s, b, r));
    end

    // Reset asserted while a fetch is outstanding.
    wait_valid();
    mem_hold = 1'b1;
    issue_adv(2'b00, 1'b0, 32'd0, ref_next(m_pc, mem_read(m_pc), 2'b00, 1'b0, 32'd0));
    @(posedge clk); #1;
    check("pre_rst_req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc", pc, 32'h0000_3000);
    check("midrst_count", inst_count, 32'd0);
    boot_model();
    mem_hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reboot_addr", imem_addr, 32'h0000_3000);
    wait_valid();

    // Wrap: PC at FFFF_FFFC must advance to 0.
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", w_pc4, 32'd0);
    w_adv = 1'b1;
    @(posedge clk); #1;
    w_adv = 1'b0;
    n = 0;
    while (!w_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr", w_addr, 32'd0);
    check("wrap_count", w_cnt, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the control decoder.
- Owns the program counter and fetches from instruction memory over a req/ack handshake.
- Holds the fetched word stable and presents inst[31:26] / inst[5:0] to the decoder.
- On the core's advance pulse, computes the next PC from the decoder's AddrSrc plus branch outcome, jump target or register target.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction.
- INSTop  out  6  inst[31:26], to decoder.
- funct  out  6  inst[5:0], to decoder.
- inst_valid  out  1  inst is valid and held.
- pc  out  ADDR_W  address of the held instruction.
- pc_plus4  out  ADDR_W  pc+4; used as link value.
- advance  in  1  core has finished executing inst; load next PC.
- AddrSrc  in  2  next-PC source: 00 origin, 01 branch, 10 jump, 11 reg.
- br_taken  in  1  branch condition result; only meaningful when AddrSrc=01.
- reg_target  in  32  rs value for jr/jalr.
- misalign  out  1  one-cycle pulse: reg target had nonzero low bits.
- inst_count  out  32  retired-instruction counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0.
  - misalign=0, inst_count=0.
  - Applies mid-fetch or mid-hold; any outstanding ack is discarded.
- States:
  - BOOT: one idle cycle after reset release; imem_req=0; go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc, inst_valid=0.
    - On imem_ack: capture imem_rdata into inst; go to HOLD.
    - Ack in the same cycle FETCH is entered is legal: zero-wait memory gives one cycle FETCH, then HOLD.
  - HOLD: imem_req=0, inst_valid=1; inst, pc and pc_plus4 stable.
    - On advance: pc <= next_pc, inst_count += 1 (wraps 32'hFFFF_FFFF -> 0), go to FETCH.
- Stray inputs:
  - advance in BOOT or FETCH: ignored; no PC change, no count.
  - imem_ack in BOOT or HOLD: ignored.
- Output decode:
  - INSTop and funct are combinational slices of the inst register.
  - They read 0 while the register is 0, which decodes as R-type funct 0 (sll), a harmless nop.
- next_pc (combinational from the held pc, evaluated in the advance cycle):
  - 00: pc+4.
  - 01: if br_taken, pc+4+(sign_extend(inst[15:0])<<2); else pc+4.
  - 10: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - 11: {reg_target[31:2], 2'b00}. If reg_target[1:0]!=0, misalign pulses high for that one cycle.
- Arithmetic:
  - Modulo 2^32; pc+4 at 32'hFFFF_FFFC wraps to 0.
  - No delay slot; link value is pc_plus4.
- Latency:
  - advance to imem_req high: 1 cycle.
  - imem_ack to inst_valid high: 1 cycle.
- misalign is registered, so it appears the cycle after advance. It is cleared on every other cycle.

Test Plan:
- Reset/boot:
  - Stimulus: rst low, then high; ack with a one-cycle delay.
  - Response: imem_req rises 1 cycle after release with imem_addr=32'h3000; inst_valid rises 1 cycle after ack; inst_count=0.
- Sequential and wrap:
  - Stimulus: advance with AddrSrc=00 three times.
  - Response: addresses 3000, 3004, 3008, 300C; inst_count=3.
  - Wrap check: force pc=FFFF_FFFC via RESET_PC override, advance; response: next addr=0.
- Branch:
  - Stimulus: held inst imm16=16'hFFFE at pc=3010.
  - br_taken=1: next addr=300C. br_taken=0: next addr=3014.
- Jump:
  - Stimulus: pc=3000, inst[25:0]=26'h0000C10, AddrSrc=10.
  - Response: next addr=0000_3040.
- Reg target:
  - Stimulus: AddrSrc=11, reg_target=0000_3043.
  - Response: next addr=0000_3040; misalign pulses high for exactly 1 cycle.
- Protocol robustness:
  - Stimulus: advance during FETCH and ack during HOLD.
  - Response: no PC or inst change.
  - Stimulus: rst asserted mid-FETCH.
  - Response: imem_req drops immediately; pc=3000.
